ex_muldiv_unit: RTL
===================

Name: ex_muldiv_unit

Overview:
Multi-cycle RV64M multiply/divide unit in the execute stage, directly upstream of the memory stage. It accepts one M-extension operation at a time from the EX issue logic, iterates a shift-add multiplier or a restoring divider, and presents the result and destination register to the EX/MEM interface under a valid/ready handshake. While an operation is in flight it drives the pipeline staller.

Parameters:
XLEN, 64, operand/result width
CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > XLEN

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous active-high reset
i_valid  in  1  operation offered
o_ready  out  1  unit can accept; equals (state==IDLE)
i_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
i_is_word  in  1  *W variant (32-bit op, sign-extended result)
i_rs1  in  XLEN  operand A
i_rs2  in  XLEN  operand B
i_rd  in  5  destination register
i_flush  in  1  kill the in-flight operation
o_valid  out  1  result available
i_ready  in  1  MEM stage accepts the result
o_result  out  XLEN  result
o_rd  out  5  destination register of the result
o_busy  out  1  staller to hazard unit

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: state IDLE, o_valid 0, o_result 0, o_rd 0, o_busy 0, counter 0. o_ready is 1 after reset.
- Accept: an operation is accepted when i_valid && o_ready && !i_flush are sampled on a clock edge. Operands, funct3, is_word and rd are latched on that edge.
- Operand prep:
  - Word ops take the low 32 bits of each operand. They are sign-extended for signed ops and zero-extended for unsigned ops.
  - Signed operands are converted to magnitudes, and the result sign is recorded.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
- Special cases, detected on the accept edge. These go straight to DONE, so o_valid is high 1 cycle after acceptance.
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU remainder = dividend.
  - Signed overflow (MIN / -1): DIV quotient = MIN; REM remainder = 0.
  - Word variants use 32-bit MIN, and the result is sign-extended.
- States and transitions:
  - IDLE -> MUL or DIV on accept.
  - MUL/DIV: one iteration per cycle. The counter counts N = 64 iterations (32 for word ops), then the state goes to FIXUP.
  - FIXUP: applies result negation, selects the high or low half (MULH*: product[127:64]; otherwise [63:0]) or quotient/remainder, and sign-extends bit 31 for word ops. Goes to DONE.
  - DONE: o_valid = 1. o_result and o_rd are held stable until i_ready. On o_valid && i_ready the state returns to IDLE.
- Latency: o_valid is first high N+2 cycles after the accept edge (66 for 64-bit, 34 for word).
- No accept in DONE: the next op can be accepted no earlier than the cycle after the handshake.
- Multiplier: 128-bit accumulator, shift-add on multiplier bit 0, multiplicand shifted left each cycle.
- Divider: restoring. 64-bit remainder register; each step shifts in the dividend MSB and subtracts the divisor, keeping the result if it is non-negative; the quotient bit is set accordingly.
- Remainder sign follows the dividend; quotient sign is the XOR of the operand signs.
- o_busy = (state in MUL, DIV, FIXUP) || (state==DONE && !i_ready).
- i_flush: in any state, the next edge returns the unit to IDLE and o_valid drops. If flush and i_valid are high in the same cycle, flush wins and nothing is accepted.
- Reset mid-operation: immediate return to the reset values; the partial result is discarded.
- Word with funct3 001..011 is not legal RV64M. It executes as MULW (low-product, sign-extended).

Decomposition:
- struct_pckg: add typedef muldiv_state_e {IDLE, MUL, DIV, FIXUP, DONE}.
- defines.sv: add the funct3 M-op constants.
- One sub-module, muldiv_sign_fixup (combinational), covering:
  - operand magnitude/extension on accept;
  - result negation, half selection and word sign-extension in FIXUP.
- The FSM, counter and iteration datapath live in ex_muldiv_unit.

Test Plan:
1. MUL with rs1=7, rs2=-3 (0xFFFF_FFFF_FFFF_FFFD), i_ready=1 -> o_valid exactly 66 cycles after accept; o_result=0xFFFF_FFFF_FFFF_FFEB; o_rd echoes i_rd; o_busy high throughout.
2. MULHU with 0xFFFF_FFFF_FFFF_FFFF × 0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE. MULH of the same operands -> 0.
3. DIV -7/2 -> -3; REM -7/2 -> -1. DIVW with rs1=0x0000_0000_8000_0000, rs2=-1 -> 1-cycle result 0xFFFF_FFFF_8000_0000. DIVU x/0 -> all ones in 1 cycle.
4. Backpressure: i_ready=0 for 10 cycles after o_valid -> o_result and o_rd stable, o_busy=1, o_ready=0. Handshake -> IDLE next cycle, o_ready=1.
5. Flush at iteration 20 of a DIV, with i_valid asserted in the same cycle -> IDLE next edge, no o_valid, new op not accepted; it is accepted on the following cycle.
6. Assert rst asynchronously mid-MUL (between edges) -> outputs 0 immediately. After release, a fresh REMUW 100/7 -> 2 at 34-cycle latency.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types and constants for the RV64M multiply/divide unit.
// Holds the FSM state encoding, funct3 op codes and operand-signedness helpers.
package ex_muldiv_unit_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL   = 3'd1,
        DIV   = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } muldiv_state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int WORD_W = 32;

    function automatic logic signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_sign_fixup.sv
// Combinational sign handling around the iterative core: operand extension and
// magnitudes at accept time, and result negation / half select / word extension at fixup.
module muldiv_sign_fixup
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]        funct3,
    input  logic              is_word,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    output logic [2:0]        op,
    output logic [XLEN-1:0]   a_ext,
    output logic [XLEN-1:0]   b_ext,
    output logic [XLEN-1:0]   mag_a,
    output logic [XLEN-1:0]   mag_b,
    output logic              neg_q,
    output logic              neg_r,
    input  logic [2:0]        fx_op,
    input  logic              fx_is_word,
    input  logic              fx_neg_q,
    input  logic              fx_neg_r,
    input  logic [2*XLEN-1:0] fx_acc,
    input  logic [XLEN-1:0]   fx_quot,
    input  logic [XLEN-1:0]   fx_rem,
    output logic [XLEN-1:0]   fx_result
);

    logic            sa_s;
    logic            sb_s;
    logic            a_neg_s;
    logic            b_neg_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0] quot_s;
    logic [XLEN-1:0] rem_s;
    logic [XLEN-1:0] raw_s;

    // Operand preparation; illegal word MULH* forms run as MULW
    always_comb begin
        op = funct3;
        if (is_word && !funct3[2]) begin
            op = F3_MUL;
        end else begin
            op = funct3;
        end
        sa_s = signed_a(op);
        sb_s = signed_b(op);
        if (is_word) begin
            a_ext = sa_s ? {{(XLEN-WORD_W){rs1[WORD_W-1]}}, rs1[WORD_W-1:0]}
                         : {{(XLEN-WORD_W){1'b0}}, rs1[WORD_W-1:0]};
            b_ext = sb_s ? {{(XLEN-WORD_W){rs2[WORD_W-1]}}, rs2[WORD_W-1:0]}
                         : {{(XLEN-WORD_W){1'b0}}, rs2[WORD_W-1:0]};
        end else begin
            a_ext = rs1;
            b_ext = rs2;
        end
        a_neg_s = sa_s && a_ext[XLEN-1];
        b_neg_s = sb_s && b_ext[XLEN-1];
        mag_a   = a_neg_s ? -a_ext : a_ext;
        mag_b   = b_neg_s ? -b_ext : b_ext;
        neg_q   = a_neg_s ^ b_neg_s;
        neg_r   = a_neg_s;
    end

    // Result fixup: restore sign, pick the requested half or quotient/remainder
    always_comb begin
        prod_s = fx_neg_q ? -fx_acc : fx_acc;
        quot_s = fx_neg_q ? -fx_quot : fx_quot;
        rem_s  = fx_neg_r ? -fx_rem : fx_rem;
        case (fx_op)
            F3_MUL:                      raw_s = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: raw_s = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             raw_s = quot_s;
            F3_REM, F3_REMU:             raw_s = rem_s;
            default:                     raw_s = {XLEN{1'b0}};
        endcase
        if (fx_is_word) begin
            fx_result = {{(XLEN-WORD_W){raw_s[WORD_W-1]}}, raw_s[WORD_W-1:0]};
        end else begin
            fx_result = raw_s;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiplier and restoring divider,
// one operation in flight, result handed to MEM under a valid/ready handshake.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_funct3,
    input  logic            i_is_word,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [4:0]      i_rd,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd,
    output logic            o_busy
);

    muldiv_state_e     state_r, state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [2:0]        op_r;
    logic              is_word_r, neg_q_r, neg_r_r;
    logic [2*XLEN-1:0] acc_r, mcand_r;
    logic [XLEN-1:0]   mplier_r, quot_r, rem_r, divisor_r;
    logic              o_valid_r;
    logic [XLEN-1:0]   o_result_r;
    logic [4:0]        o_rd_r;

    logic [2:0]        op_s;
    logic [XLEN-1:0]   a_ext_s, b_ext_s, mag_a_s, mag_b_s, fix_res_s;
    logic              neg_q_s, neg_r_s;
    logic              accept_s, div0_s, ovf_s, special_s, last_s;
    logic [XLEN-1:0]   min_s, spec_raw_s, spec_res_s;
    logic [XLEN+1:0]   trial_s;

    muldiv_sign_fixup #(.XLEN(XLEN)) u_sign_fixup (
        .funct3     (i_funct3),
        .is_word    (i_is_word),
        .rs1        (i_rs1),
        .rs2        (i_rs2),
        .op         (op_s),
        .a_ext      (a_ext_s),
        .b_ext      (b_ext_s),
        .mag_a      (mag_a_s),
        .mag_b      (mag_b_s),
        .neg_q      (neg_q_s),
        .neg_r      (neg_r_s),
        .fx_op      (op_r),
        .fx_is_word (is_word_r),
        .fx_neg_q   (neg_q_r),
        .fx_neg_r   (neg_r_r),
        .fx_acc     (acc_r),
        .fx_quot    (quot_r),
        .fx_rem     (rem_r),
        .fx_result  (fix_res_s)
    );

    assign accept_s  = i_valid && (state_r == IDLE) && !i_flush;
    assign min_s     = i_is_word ? {{(XLEN-WORD_W+1){1'b1}}, {(WORD_W-1){1'b0}}}
                                 : {1'b1, {(XLEN-1){1'b0}}};
    assign div0_s    = op_s[2] && (b_ext_s == {XLEN{1'b0}});
    assign ovf_s     = ((op_s == F3_DIV) || (op_s == F3_REM)) &&
                       (a_ext_s == min_s) && (b_ext_s == {XLEN{1'b1}});
    assign special_s = div0_s || ovf_s;
    assign last_s    = (cnt_r == (is_word_r ? CNT_W'(WORD_W-1) : CNT_W'(XLEN-1)));
    // Restoring step: shifted partial remainder minus divisor, sign in the top bit
    assign trial_s   = {1'b0, rem_r, quot_r[XLEN-1]} - {2'b00, divisor_r};

    assign o_ready  = (state_r == IDLE);
    assign o_busy   = (state_r == MUL) || (state_r == DIV) || (state_r == FIXUP) ||
                      ((state_r == DONE) && !i_ready);
    assign o_valid  = o_valid_r;
    assign o_result = o_result_r;
    assign o_rd     = o_rd_r;

    // Short-circuit results for divide-by-zero and signed overflow
    always_comb begin
        spec_raw_s = a_ext_s;
        if (op_s[1]) begin
            spec_raw_s = ovf_s ? {XLEN{1'b0}} : a_ext_s;
        end else begin
            spec_raw_s = div0_s ? {XLEN{1'b1}} : a_ext_s;
        end
        if (i_is_word) begin
            spec_res_s = {{(XLEN-WORD_W){spec_raw_s[WORD_W-1]}}, spec_raw_s[WORD_W-1:0]};
        end else begin
            spec_res_s = spec_raw_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        if (i_flush) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_valid) begin
                        state_s = special_s ? DONE : (op_s[2] ? DIV : MUL);
                    end else begin
                        state_s = IDLE;
                    end
                end
                MUL, DIV: begin
                    if (last_s) begin
                        state_s = FIXUP;
                    end else begin
                        state_s = state_r;
                    end
                end
                FIXUP: state_s = DONE;
                DONE: begin
                    if (i_ready) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DONE;
                    end
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latch and one shift-add / restoring-divide iteration per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= {CNT_W{1'b0}};
            op_r      <= 3'b000;
            is_word_r <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            acc_r     <= {(2*XLEN){1'b0}};
            mcand_r   <= {(2*XLEN){1'b0}};
            mplier_r  <= {XLEN{1'b0}};
            quot_r    <= {XLEN{1'b0}};
            rem_r     <= {XLEN{1'b0}};
            divisor_r <= {XLEN{1'b0}};
        end else if (accept_s) begin
            cnt_r     <= {CNT_W{1'b0}};
            op_r      <= op_s;
            is_word_r <= i_is_word;
            neg_q_r   <= neg_q_s;
            neg_r_r   <= neg_r_s;
            acc_r     <= {(2*XLEN){1'b0}};
            mcand_r   <= {{XLEN{1'b0}}, mag_a_s};
            mplier_r  <= mag_b_s;
            // Word dividends sit in the top half so their MSB shifts in first
            quot_r    <= i_is_word ? {mag_a_s[WORD_W-1:0], {(XLEN-WORD_W){1'b0}}} : mag_a_s;
            rem_r     <= {XLEN{1'b0}};
            divisor_r <= mag_b_s;
        end else if (state_r == MUL) begin
            cnt_r    <= cnt_r + CNT_W'(1);
            acc_r    <= mplier_r[0] ? (acc_r + mcand_r) : acc_r;
            mcand_r  <= {mcand_r[2*XLEN-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
        end else if (state_r == DIV) begin
            cnt_r  <= cnt_r + CNT_W'(1);
            rem_r  <= trial_s[XLEN+1] ? {rem_r[XLEN-2:0], quot_r[XLEN-1]} : trial_s[XLEN-1:0];
            quot_r <= {quot_r[XLEN-2:0], ~trial_s[XLEN+1]};
        end
    end

    // Registered result interface toward MEM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid_r  <= 1'b0;
            o_result_r <= {XLEN{1'b0}};
            o_rd_r     <= 5'd0;
        end else begin
            o_valid_r <= (state_s == DONE);
            if (accept_s) begin
                o_rd_r <= i_rd;
                if (special_s) begin
                    o_result_r <= spec_res_s;
                end
            end else if ((state_r == FIXUP) && !i_flush) begin
                o_result_r <= fix_res_s;
            end
        end
    end

endmodule
